// File: rtl/ecc_drbg_pkg.sv
// ---------------------------------------------------------------------------
// ecc_drbg_pkg
// Shared types and constants for the LFSR-based ECC DRBG responder.
//   state_t      : responder FSM states
//   LFSR_WIDTH   : width of the Fibonacci LFSR (x^148 + x^121 + 1)
//   LFSR_TAPS    : tap mask, bit n-1 set for every polynomial term x^n
//   WORD_W       : LFSR bits harvested per GEN cycle
//   fold148()    : XOR of all 148-bit slices of a zero-padded input word
// ---------------------------------------------------------------------------
package ecc_drbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LFSR_WIDTH = 148;
    localparam int WORD_W     = 32;

    // Taps for x^148 and x^121 -> state bits 147 and 120.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS =
        (148'd1 << 147) | (148'd1 << 120);

    localparam logic [LFSR_WIDTH-1:0] LFSR_DEFAULT_SEED =
        148'h6_04E7_A407_54F1_4487_A021_11AC_D0DF_8C55_57A0;

    // Widest input fold148 accepts; callers zero-extend to this width, so
    // the unused upper slices contribute nothing to the XOR.
    localparam int FOLD_SLICES = 8;
    localparam int FOLD_MAX_W  = FOLD_SLICES * LFSR_WIDTH;

    function automatic logic [LFSR_WIDTH-1:0] fold148(input logic [FOLD_MAX_W-1:0] x);
        logic [LFSR_WIDTH-1:0] acc;
        acc = '0;
        for (int s = 0; s < FOLD_SLICES; s++) begin
            acc = acc ^ x[s*LFSR_WIDTH +: LFSR_WIDTH];
        end
        return acc;
    endfunction

endpackage

// File: rtl/ecc_lfsr148_step32.sv
// ---------------------------------------------------------------------------
// ecc_lfsr148_step32
// Combinational advance of the 148-bit Fibonacci LFSR by WORD_W steps.
// Each step shifts left and inserts the tap parity at bit 0, so after the
// advance the low WORD_W bits hold the new output bits, oldest in the MSB.
//   i_state : current LFSR state
//   o_state : state after WORD_W steps
// ---------------------------------------------------------------------------
module ecc_lfsr148_step32
    import ecc_drbg_pkg::*;
(
    input  logic [LFSR_WIDTH-1:0] i_state,
    output logic [LFSR_WIDTH-1:0] o_state
);

    logic [LFSR_WIDTH-1:0] w_s;

    always_comb begin
        w_s = i_state;
        for (int k = 0; k < WORD_W; k++) begin
            w_s = {w_s[LFSR_WIDTH-2:0], ^(w_s & LFSR_TAPS)};
        end
        o_state = w_s;
    end

endmodule

// File: rtl/ecc_drbg_lfsr_responder.sv
// ---------------------------------------------------------------------------
// ecc_drbg_lfsr_responder
// Fast stand-in for hmac_drbg: same command handshake, but results come from
// a 148-bit LFSR with rejection sampling into [1, HMAC_DRBG_PRIME-1].
//   clk, reset_n : clock, async active-low reset
//   zeroize      : synchronous clear to reset state, highest priority
//   init_cmd     : reseed from lfsr_seed/entropy/nonce and generate
//   next_cmd     : generate from current LFSR state (after an init)
//   lfsr_seed, entropy, nonce : seed material, sampled on init accept
//   ready        : idle, commands accepted this cycle
//   valid        : drbg holds the result of the last command
//   drbg         : result (0 on fail)
//   fail         : last command exhausted MAX_RETRY candidates
//   reject_cnt   : saturating rejection count of the last command
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready=1, waiting for init_cmd / next_cmd
// ST_GEN   | harvest one 32-bit word per cycle into the candidate register
// ST_CHECK | range test; accept, retry, or give up
// ST_DONE  | raise valid, return to idle
// ---------------------------------------------------------------------------
module ecc_drbg_lfsr_responder
    import ecc_drbg_pkg::*;
#(
    parameter int                    REG_SIZE        = 384,
    parameter logic [REG_SIZE-1:0]   HMAC_DRBG_PRIME =
        384'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFC7634D81F4372DDF581A0DB248B0A77AECEC196ACCC52973,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT_SEED  = LFSR_DEFAULT_SEED,
    parameter int                    MAX_RETRY       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  zeroize,
    input  logic                  init_cmd,
    input  logic                  next_cmd,
    input  logic [LFSR_WIDTH-1:0] lfsr_seed,
    input  logic [REG_SIZE-1:0]   entropy,
    input  logic [REG_SIZE-1:0]   nonce,
    output logic                  ready,
    output logic                  valid,
    output logic [REG_SIZE-1:0]   drbg,
    output logic                  fail,
    output logic [7:0]            reject_cnt
);

    localparam int         WORDS      = REG_SIZE / WORD_W;
    localparam logic [7:0] WORD_LAST  = 8'(WORDS - 1);
    localparam logic [7:0] RETRY_LAST = 8'(MAX_RETRY - 1);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic [REG_SIZE-1:0]   r_cand;
    logic [REG_SIZE-1:0]   r_drbg;
    logic [7:0]            r_word_cnt;
    logic [7:0]            r_retry;
    logic [7:0]            r_reject_cnt;
    logic                  r_valid;
    logic                  r_fail;
    logic                  r_instantiated;

    logic                  w_accept_init;
    logic                  w_accept_next;
    logic                  w_accept;
    logic                  w_last_word;
    logic                  w_in_range;
    logic                  w_can_retry;
    logic [LFSR_WIDTH-1:0] w_lfsr_next;
    logic [LFSR_WIDTH-1:0] w_seed_mix;
    logic [FOLD_MAX_W-1:0] w_entropy_pad;
    logic [FOLD_MAX_W-1:0] w_nonce_pad;
    logic [7:0]            w_reject_inc;

    ecc_lfsr148_step32 u_step (
        .i_state (r_lfsr),
        .o_state (w_lfsr_next)
    );

    assign w_entropy_pad = {{(FOLD_MAX_W-REG_SIZE){1'b0}}, entropy};
    assign w_nonce_pad   = {{(FOLD_MAX_W-REG_SIZE){1'b0}}, nonce};
    assign w_seed_mix    = lfsr_seed ^ fold148(w_entropy_pad) ^ fold148(w_nonce_pad);

    // init wins over next; next is only honoured once instantiated.
    assign w_accept_init = (r_state == ST_IDLE) && init_cmd;
    assign w_accept_next = (r_state == ST_IDLE) && !init_cmd && next_cmd && r_instantiated;
    assign w_accept      = w_accept_init || w_accept_next;

    assign w_last_word   = (r_word_cnt == WORD_LAST);
    assign w_in_range    = (r_cand != '0) && (r_cand < HMAC_DRBG_PRIME);
    assign w_can_retry   = (r_retry < RETRY_LAST);
    assign w_reject_inc  = (r_reject_cnt == 8'hFF) ? 8'hFF : (r_reject_cnt + 8'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_GEN;
            ST_GEN:   if (w_last_word) w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (w_in_range || !w_can_retry) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_GEN;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (zeroize) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr         <= LFSR_INIT_SEED;
            r_cand         <= '0;
            r_drbg         <= '0;
            r_word_cnt     <= '0;
            r_retry        <= '0;
            r_reject_cnt   <= '0;
            r_valid        <= 1'b0;
            r_fail         <= 1'b0;
            r_instantiated <= 1'b0;
        end else if (zeroize) begin
            r_lfsr         <= LFSR_INIT_SEED;
            r_cand         <= '0;
            r_drbg         <= '0;
            r_word_cnt     <= '0;
            r_retry        <= '0;
            r_reject_cnt   <= '0;
            r_valid        <= 1'b0;
            r_fail         <= 1'b0;
            r_instantiated <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_valid      <= 1'b0;
                        r_fail       <= 1'b0;
                        r_reject_cnt <= '0;
                        r_word_cnt   <= '0;
                        r_retry      <= '0;
                    end
                    if (w_accept_init) begin
                        // An all-zero LFSR would lock up; fall back to the fixed seed.
                        r_lfsr         <= (w_seed_mix == '0) ? LFSR_INIT_SEED : w_seed_mix;
                        r_instantiated <= 1'b1;
                    end
                end
                ST_GEN: begin
                    r_lfsr     <= w_lfsr_next;
                    r_cand     <= (r_cand << WORD_W) | REG_SIZE'(w_lfsr_next[WORD_W-1:0]);
                    r_word_cnt <= r_word_cnt + 8'd1;
                end
                ST_CHECK: begin
                    if (w_in_range) begin
                        r_drbg <= r_cand;
                    end else if (w_can_retry) begin
                        r_retry      <= r_retry + 8'd1;
                        r_reject_cnt <= w_reject_inc;
                        r_word_cnt   <= '0;
                    end else begin
                        r_drbg       <= '0;
                        r_fail       <= 1'b1;
                        r_reject_cnt <= w_reject_inc;
                    end
                end
                ST_DONE: begin
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready      = (r_state == ST_IDLE);
    assign valid      = r_valid;
    assign drbg       = r_drbg;
    assign fail       = r_fail;
    assign reject_cnt = r_reject_cnt;

endmodule

// File: tb/tb_ecc_drbg_lfsr_responder.sv
module tb_ecc_drbg_lfsr_responder;

    localparam logic [383:0] P384 =
        384'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFC7634D81F4372DDF581A0DB248B0A77AECEC196ACCC52973;
    localparam logic [383:0] PRIME_B   = 384'd1 << 383;
    localparam logic [383:0] PRIME_C   = 384'd1;
    localparam logic [147:0] INIT_SEED = 148'h6_04E7_A407_54F1_4487_A021_11AC_D0DF_8C55_57A0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          zeroize;
    logic          init_cmd [3];
    logic          next_cmd [3];
    logic [147:0]  lfsr_seed;
    logic [383:0]  entropy;
    logic [383:0]  nonce;
    logic          ready [3];
    logic          valid [3];
    logic          fail [3];
    logic [383:0]  drbg [3];
    logic [7:0]    rej [3];

    int            checks = 0;
    int            errors = 0;
    logic [147:0]  m_lfsr [3];

    always #5 clk = ~clk;

    // u_a: default parameters; u_b: prime 2^383; u_c: prime 1, 4 retries.
    ecc_drbg_lfsr_responder u_a (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
        .init_cmd(init_cmd[0]), .next_cmd(next_cmd[0]),
        .lfsr_seed(lfsr_seed), .entropy(entropy), .nonce(nonce),
        .ready(ready[0]), .valid(valid[0]), .drbg(drbg[0]),
        .fail(fail[0]), .reject_cnt(rej[0])
    );

    ecc_drbg_lfsr_responder #(.HMAC_DRBG_PRIME(PRIME_B)) u_b (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
        .init_cmd(init_cmd[1]), .next_cmd(next_cmd[1]),
        .lfsr_seed(lfsr_seed), .entropy(entropy), .nonce(nonce),
        .ready(ready[1]), .valid(valid[1]), .drbg(drbg[1]),
        .fail(fail[1]), .reject_cnt(rej[1])
    );

    ecc_drbg_lfsr_responder #(.HMAC_DRBG_PRIME(PRIME_C), .MAX_RETRY(4)) u_c (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
        .init_cmd(init_cmd[2]), .next_cmd(next_cmd[2]),
        .lfsr_seed(lfsr_seed), .entropy(entropy), .nonce(nonce),
        .ready(ready[2]), .valid(valid[2]), .drbg(drbg[2]),
        .fail(fail[2]), .reject_cnt(rej[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [147:0] m_fold(input logic [383:0] x);
        return x[147:0] ^ x[295:148] ^ {60'd0, x[383:296]};
    endfunction

    task automatic m_init(input int idx);
        logic [147:0] mix;
        mix = lfsr_seed ^ m_fold(entropy) ^ m_fold(nonce);
        m_lfsr[idx] = (mix == 148'd0) ? INIT_SEED : mix;
    endtask

    // Bit-serial generator: first output bit lands in the candidate MSB.
    task automatic m_gen(input int idx, output logic [383:0] cand);
        logic [147:0] st;
        logic         fb;
        st   = m_lfsr[idx];
        cand = '0;
        for (int i = 0; i < 384; i++) begin
            fb   = st[147] ^ st[120];
            st   = {st[146:0], fb};
            cand = {cand[382:0], fb};
        end
        m_lfsr[idx] = st;
    endtask

    task automatic model_cmd(input int idx, output logic [383:0] e_drbg,
                             output int e_rej, output bit e_fail, output int e_lat);
        logic [383:0] prime;
        logic [383:0] cand;
        int           maxr;
        prime  = (idx == 0) ? P384 : (idx == 1) ? PRIME_B : PRIME_C;
        maxr   = (idx == 2) ? 4 : 16;
        e_rej  = 0;
        e_fail = 1'b0;
        e_drbg = '0;
        for (int r = 0; r < maxr; r++) begin
            m_gen(idx, cand);
            if (cand != 384'd0 && cand < prime) begin
                e_drbg = cand;
                break;
            end
            e_rej++;
            if (e_rej == maxr) e_fail = 1'b1;
        end
        e_lat = e_fail ? (14 + 13 * (maxr - 1)) : (14 + 13 * e_rej);
    endtask

    // ---------------- stimulus helper ----------------
    // Issues a command at the next rising edge (edge 0) and returns the edge
    // number after which valid was first seen, or -1 on timeout. A nonzero
    // disturb value pulses init+next with altered entropy during that cycle.
    task automatic run_cmd(input int idx, input bit do_init, input bit do_next,
                           input int disturb, output int lat);
        logic [383:0] saved;
        @(negedge clk);
        init_cmd[idx] = do_init;
        next_cmd[idx] = do_next;
        @(posedge clk);
        @(negedge clk);
        init_cmd[idx] = 1'b0;
        next_cmd[idx] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 300; c++) begin
            saved = entropy;
            if (c == disturb) begin
                init_cmd[idx] = 1'b1;
                next_cmd[idx] = 1'b1;
                entropy       = ~entropy;
            end
            @(posedge clk);
            @(negedge clk);
            if (c == disturb) begin
                init_cmd[idx] = 1'b0;
                next_cmd[idx] = 1'b0;
                entropy       = saved;
            end
            if (valid[idx]) begin
                lat = c;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ready[i] !== 1'b1 || valid[i] !== 1'b0 || fail[i] !== 1'b0 ||
                drbg[i] !== 384'd0 || rej[i] !== 8'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: ready=%b valid=%b fail=%b rej=%0d drbg=%h, required 1 0 0 0 0",
                         i, ready[i], valid[i], fail[i], rej[i], drbg[i]);
            end
        end
        @(negedge clk);
        next_cmd[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ready[0] !== 1'b1 || valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL next_uninst cycle %0d: ready=%b valid=%b, required 1 0", c, ready[0], valid[0]);
            end
        end
        next_cmd[0] = 1'b0;
    endtask

    task automatic test_init_zero();
        logic [383:0] e_drbg, first;
        int           e_rej, e_lat, lat;
        bit           e_fail;
        lfsr_seed = '0; entropy = '0; nonce = '0;
        m_init(0);
        checks++;
        if (m_lfsr[0] !== INIT_SEED) begin
            errors++;
            $display("FAIL model_seed: got %h required %h", m_lfsr[0], INIT_SEED);
        end
        model_cmd(0, e_drbg, e_rej, e_fail, e_lat);
        first = e_drbg;
        run_cmd(0, 1'b1, 1'b0, 0, lat);
        checks++;
        if (lat !== 14) begin
            errors++;
            $display("FAIL init_zero_latency: got %0d required 14", lat);
        end
        checks++;
        if (drbg[0] !== e_drbg) begin
            errors++;
            $display("FAIL init_zero_drbg: got %h required %h", drbg[0], e_drbg);
        end
        checks++;
        if (rej[0] !== 8'd0 || fail[0] !== 1'b0 || ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL init_zero_flags: rej=%0d fail=%b ready=%b, required 0 0 1", rej[0], fail[0], ready[0]);
        end
        // next continues from the advanced state
        model_cmd(0, e_drbg, e_rej, e_fail, e_lat);
        run_cmd(0, 1'b0, 1'b1, 0, lat);
        checks++;
        if (drbg[0] !== e_drbg || lat !== e_lat) begin
            errors++;
            $display("FAIL next_after_zero: got %h lat %0d required %h lat %0d", drbg[0], lat, e_drbg, e_lat);
        end
        checks++;
        if (drbg[0] === first) begin
            errors++;
            $display("FAIL next_reseeded: got %h which must differ from %h", drbg[0], first);
        end
        // seed material that cancels to zero also falls back to the fixed seed
        lfsr_seed = 148'd1; entropy = 384'd1; nonce = '0;
        run_cmd(0, 1'b1, 1'b0, 0, lat);
        m_init(0);
        model_cmd(0, e_drbg, e_rej, e_fail, e_lat);
        checks++;
        if (drbg[0] !== first || lat !== 14) begin
            errors++;
            $display("FAIL cancel_seed: got %h lat %0d required %h lat 14", drbg[0], lat, first);
        end
    endtask

    task automatic test_range();
        logic [383:0] e_drbg;
        logic [159:0] s;
        int           e_rej, e_lat, lat;
        bit           e_fail;
        for (int seq = 0; seq < 34; seq++) begin
            for (int k = 0; k < 5; k++)  s[k*32 +: 32] = $urandom();
            for (int k = 0; k < 12; k++) entropy[k*32 +: 32] = $urandom();
            for (int k = 0; k < 12; k++) nonce[k*32 +: 32] = $urandom();
            lfsr_seed = s[147:0];
            m_init(1);
            for (int cmd = 0; cmd < 3; cmd++) begin
                model_cmd(1, e_drbg, e_rej, e_fail, e_lat);
                run_cmd(1, cmd == 0, cmd != 0, 0, lat);
                checks++;
                if (drbg[1] !== e_drbg || rej[1] !== 8'(e_rej) || fail[1] !== e_fail) begin
                    errors++;
                    $display("FAIL range_seq%0d_cmd%0d: drbg %h rej %0d fail %b, required %h rej %0d fail %b",
                             seq, cmd, drbg[1], rej[1], fail[1], e_drbg, e_rej, e_fail);
                end
                checks++;
                if (lat !== e_lat) begin
                    errors++;
                    $display("FAIL range_latency seq%0d cmd%0d: got %0d required %0d", seq, cmd, lat, e_lat);
                end
                if (!e_fail) begin
                    checks++;
                    if (drbg[1] === 384'd0 || drbg[1][383] !== 1'b0) begin
                        errors++;
                        $display("FAIL range_bound seq%0d cmd%0d: got %h required in [1, 2^383-1]", seq, cmd, drbg[1]);
                    end
                end
            end
        end
    endtask

    task automatic test_fail();
        int lat;
        lfsr_seed = 148'h5A5A_1234; entropy = {12{32'hDEAD_BEEF}}; nonce = 384'h77;
        for (int cmd = 0; cmd < 2; cmd++) begin
            run_cmd(2, cmd == 0, cmd != 0, 0, lat);
            checks++;
            if (lat !== 53) begin
                errors++;
                $display("FAIL fail_latency cmd%0d: got %0d required 53", cmd, lat);
            end
            checks++;
            if (fail[2] !== 1'b1 || drbg[2] !== 384'd0 || rej[2] !== 8'd4 || ready[2] !== 1'b1) begin
                errors++;
                $display("FAIL fail_result cmd%0d: fail=%b drbg=%h rej=%0d ready=%b, required 1 0 4 1",
                         cmd, fail[2], drbg[2], rej[2], ready[2]);
            end
        end
    endtask

    task automatic test_init_and_next();
        logic [383:0] e1, e2;
        int           e_rej, e_lat, lat;
        bit           e_fail;
        lfsr_seed = 148'hABCDE_0123_4567; entropy = {6{64'h0F1E_2D3C_4B5A_6978}}; nonce = {12{32'h1357_9BDF}};
        m_init(0);
        model_cmd(0, e1, e_rej, e_fail, e_lat);
        run_cmd(0, 1'b1, 1'b0, 0, lat);
        checks++;
        if (drbg[0] !== e1 || lat !== e_lat) begin
            errors++;
            $display("FAIL init_only: got %h lat %0d required %h lat %0d", drbg[0], lat, e1, e_lat);
        end
        run_cmd(0, 1'b1, 1'b1, 0, lat);
        checks++;
        if (drbg[0] !== e1 || lat !== e_lat) begin
            errors++;
            $display("FAIL init_and_next: got %h lat %0d required %h lat %0d", drbg[0], lat, e1, e_lat);
        end
        run_cmd(0, 1'b1, 1'b0, 3, lat);
        checks++;
        if (drbg[0] !== e1 || lat !== e_lat) begin
            errors++;
            $display("FAIL cmd_during_gen: got %h lat %0d required %h lat %0d", drbg[0], lat, e1, e_lat);
        end
        model_cmd(0, e2, e_rej, e_fail, e_lat);
        run_cmd(0, 1'b0, 1'b1, 0, lat);
        checks++;
        if (drbg[0] !== e2 || lat !== e_lat) begin
            errors++;
            $display("FAIL next_after_busy: got %h lat %0d required %h lat %0d", drbg[0], lat, e2, e_lat);
        end
    endtask

    task automatic test_zeroize();
        logic [383:0] e_drbg;
        int           e_rej, e_lat, lat;
        bit           e_fail;
        lfsr_seed = 148'h1_F00D; entropy = {12{32'hCAFE_F00D}}; nonce = '0;
        @(negedge clk);
        init_cmd[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init_cmd[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        zeroize = 1'b1;
        @(posedge clk);
        @(negedge clk);
        zeroize = 1'b0;
        checks++;
        if (ready[0] !== 1'b1 || valid[0] !== 1'b0 || drbg[0] !== 384'd0 ||
            fail[0] !== 1'b0 || rej[0] !== 8'd0) begin
            errors++;
            $display("FAIL zeroize_state: ready=%b valid=%b fail=%b rej=%0d drbg=%h, required 1 0 0 0 0",
                     ready[0], valid[0], fail[0], rej[0], drbg[0]);
        end
        next_cmd[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ready[0] !== 1'b1 || valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL next_after_zeroize cycle %0d: ready=%b valid=%b, required 1 0", c, ready[0], valid[0]);
            end
        end
        next_cmd[0] = 1'b0;
        m_init(0);
        model_cmd(0, e_drbg, e_rej, e_fail, e_lat);
        run_cmd(0, 1'b1, 1'b0, 0, lat);
        checks++;
        if (drbg[0] !== e_drbg || lat !== e_lat) begin
            errors++;
            $display("FAIL init_after_zeroize: got %h lat %0d required %h lat %0d", drbg[0], lat, e_drbg, e_lat);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        zeroize   = 1'b0;
        lfsr_seed = '0;
        entropy   = '0;
        nonce     = '0;
        for (int i = 0; i < 3; i++) begin
            init_cmd[i] = 1'b0;
            next_cmd[i] = 1'b0;
            m_lfsr[i]   = INIT_SEED;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_init_zero();
        test_range();
        test_fail();
        test_init_and_next();
        test_zeroize();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
